// File: rtl/mul16s_arb_pkg.sv
// Shared types, widths and the approximate multiply for mul16s_share_arb.
package mul16s_arb_pkg;

    localparam int DATA_W     = 16;
    localparam int PROD_W     = 32;
    localparam int TRUNC_BITS = 2;
    localparam logic [3:0] BIAS = 4'b0100;

    // The request struct is sized for the widest supported configuration;
    // the top fills only the low TAG_W / id bits (TAG_W <= TAG_MAX_W, NREQ <= 16).
    localparam int TAG_MAX_W = 16;
    localparam int ID_MAX_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [TAG_MAX_W-1:0] tag;
        logic [ID_MAX_W-1:0]  id;
    } mul_req_t;

    // Drop the two LSBs of each operand, multiply the 14-bit signed remainders,
    // and append a constant bias that re-centres the truncation error.
    function automatic logic [PROD_W-1:0] approx_mul(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic signed [DATA_W-TRUNC_BITS-1:0]     za;
        logic signed [DATA_W-TRUNC_BITS-1:0]     zb;
        logic signed [2*(DATA_W-TRUNC_BITS)-1:0] z;
        za = a[DATA_W-1:TRUNC_BITS];
        zb = b[DATA_W-1:TRUNC_BITS];
        z  = (2*(DATA_W-TRUNC_BITS))'(za) * (2*(DATA_W-TRUNC_BITS))'(zb);
        return {z, BIAS};
    endfunction

endpackage

// File: rtl/mul16s_share_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Walk candidates ptr, ptr+1, ... (mod N) and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N))
                sum = sum - (IDX_W+1)'(N);
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mul16s_share_arb.sv
// Round-robin share of one 16x16 signed multiplier across NREQ requesters,
// with an operand stage (S1) and a product stage (S2), both elastic.
// Define MUL16S_ARB_EXACT_EN for the exact A*B product instead of the
// truncated-operand approximation.
module mul16s_share_arb
    import mul16s_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int TAG_W = 4,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DATA_W-1:0]  req_a,
    input  logic [NREQ*DATA_W-1:0]  req_b,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [PROD_W-1:0]       rsp_prod,
    output logic                    busy
);

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              s1_vld_q, s1_vld_d;
    mul_req_t          s1_q, s1_d;
    logic              s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d;

    logic              s1_accept, s2_adv, hs;
    logic [PROD_W-1:0] prod_c;
    logic              unused_s1;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s2_adv    = !s2_vld_q | rsp_ready;
    assign s1_accept = !s1_vld_q | s2_adv;
    // Gated by reset_n so no requester sees a handshake while reset is held.
    assign req_ready = (reset_n && s1_accept) ? grant : '0;
    assign hs        = |req_ready;

`ifdef MUL16S_ARB_EXACT_EN
    assign prod_c = PROD_W'($signed(s1_q.a)) * PROD_W'($signed(s1_q.b));
`else
    assign prod_c = approx_mul(s1_q.a, s1_q.b);
`endif

    // Pad bits of the shared request struct carry no information here.
    assign unused_s1 = ^{s1_q.tag, s1_q.id};

    // Arbitration pointer and S1 capture of the granted request.
    always_comb begin
        ptr_d    = ptr_q;
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        if (s1_accept) begin
            s1_vld_d = hs;
            if (hs) begin
                s1_d                 = '0;
                s1_d.a               = req_a[grant_idx*DATA_W +: DATA_W];
                s1_d.b               = req_b[grant_idx*DATA_W +: DATA_W];
                s1_d.tag[TAG_W-1:0]  = req_tag[grant_idx*TAG_W +: TAG_W];
                s1_d.id[ID_W-1:0]    = grant_idx;
                ptr_d = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // S1 -> S2 move; the product is formed on the transfer and held while stalled.
    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_id_d   = s2_id_q;
        s2_tag_d  = s2_tag_q;
        s2_prod_d = s2_prod_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_id_d   = s1_q.id[ID_W-1:0];
                s2_tag_d  = s1_q.tag[TAG_W-1:0];
                s2_prod_d = prod_c;
            end
        end
    end

    // State registers; reset drops any in-flight entries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_id_q   <= '0;
            s2_tag_q  <= '0;
            s2_prod_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            s2_vld_q  <= s2_vld_d;
            s2_id_q   <= s2_id_d;
            s2_tag_q  <= s2_tag_d;
            s2_prod_q <= s2_prod_d;
        end
    end

    assign rsp_valid = s2_vld_q;
    assign rsp_id    = s2_id_q;
    assign rsp_tag   = s2_tag_q;
    assign rsp_prod  = s2_prod_q;
    assign busy      = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_mul16s_share_arb.sv
// Scoreboard bench for mul16s_share_arb: expected products are pushed at
// handshake time, a monitor pops and compares on every response handshake.
module tb_mul16s_share_arb;

    localparam int NREQ  = 4;
    localparam int TAG_W = 4;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*16-1:0]      req_a;
    logic [NREQ*16-1:0]      req_b;
    logic [NREQ*TAG_W-1:0]   req_tag;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [TAG_W-1:0]        rsp_tag;
    logic [31:0]             rsp_prod;
    logic                    busy;

    mul16s_share_arb #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Hand-computed vectors: A, B and product for the build's multiply mode.
    logic [15:0] VA [0:6] = '{16'h0004, 16'hFFFC, 16'h7FFF, 16'h0000,
                              16'h8000, 16'h8000, 16'h0013};
    logic [15:0] VB [0:6] = '{16'h0004, 16'h0004, 16'h7FFF, 16'h1234,
                              16'h8000, 16'h7FFF, 16'hFFF5};
`ifdef MUL16S_ARB_EXACT_EN
    logic [31:0] VP [0:6] = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h3FFF_0001, 32'h0000_0000,
                              32'h4000_0000, 32'hC000_8000, 32'hFFFF_FF2F};
`else
    logic [31:0] VP [0:6] = '{32'h0000_0014, 32'hFFFF_FFF4, 32'h3FFC_0014, 32'h0000_0004,
                              32'h4000_0004, 32'hC002_0004, 32'hFFFF_FF44};
`endif

    typedef struct {
        int          id;
        logic [3:0]  tag;
        logic [31:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response handshake must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d prod 0x%08h expected no response at %0t",
                         rsp_id, rsp_prod, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id",   32'(rsp_id),  e.id);
                chk("rsp_tag",  32'(rsp_tag), 32'(e.tag));
                chk("rsp_prod", rsp_prod,     e.prod);
            end
        end
    end

    task automatic load(input int id, input int v, input logic [3:0] tag);
        req_a[id*16 +: 16]      = VA[v];
        req_b[id*16 +: 16]      = VB[v];
        req_tag[id*TAG_W +: TAG_W] = tag;
        req_valid[id]           = 1'b1;
    endtask

    // Present a request and hold it until granted; push the expected response
    // on the handshake, then release valid just after that edge.
    task automatic send(input int id, input int v, input logic [3:0] tag);
        int   cyc;
        logic got;
        load(id, v, tag);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clock);
            if (req_ready[id]) got = 1'b1;
            else cyc++;
        end
        if (got) begin
            exp_q.push_back('{id, tag, VP[v]});
            @(posedge clock);
            #1;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: requester %0d got no req_ready, expected a grant within 50 cycles", id);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        reset_n   = 1'b0;

        // Reset state, with requests present to show req_ready is held low.
        repeat (2) @(posedge clock);
        #1 req_valid = '1;
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_rsp_prod",  rsp_prod,       0);
        chk("rst_rsp_id",    32'(rsp_id),    0);
        chk("rst_rsp_tag",   32'(rsp_tag),   0);
        req_valid = '0;
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Basic product and latency: valid appears after the second edge.
        send(0, 0, 4'h1);
        @(negedge clock);
        chk("lat_edge_k_valid", 32'(rsp_valid), 0);
        chk("lat_edge_k_busy",  32'(busy),      1);
        @(negedge clock);
        chk("lat_edge_k1_valid", 32'(rsp_valid), 1);
        drain();

        // Sign and extreme operands through varying requesters.
        for (int v = 1; v < 7; v++)
            send(v % NREQ, v, 4'(v));
        drain();

        // Backpressure: fill both stages, stall 5 cycles, then release.
        rsp_ready = 1'b0;
        send(0, 2, 4'hA);
        send(1, 5, 4'hB);
        load(2, 6, 4'hC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_prod",  rsp_prod,       VP[2]);
            chk("bp_rsp_id",    32'(rsp_id),    0);
            chk("bp_rsp_tag",   32'(rsp_tag),   32'h0000_000A);
        end
        @(posedge clock);
        #1 rsp_ready = 1'b1;
        send(2, 6, 4'hC);
        drain();

        // Reset mid-flight with both stages full and the pointer moved off 0.
        rsp_ready = 1'b0;
        send(0, 0, 4'h1);
        send(1, 1, 4'h2);
        load(3, 3, 4'h3);
        reset_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_busy",      32'(busy),      0);
        chk("midrst_req_ready", 32'(req_ready), 0);
        exp_q.delete();
        req_valid = '0;
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_idle", 32'(rsp_valid), 0);
        end

        // Fairness and full throughput: all requesters valid, 8 grants 0,1,2,3,0,1,2,3.
        @(posedge clock);
        #1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                exp_q.push_back('{i, 4'(8 + i), VP[i]});
        for (int i = 0; i < NREQ; i++)
            load(i, i, 4'(8 + i));
        fork
            begin
                int cnt;
                int cyc;
                cnt = 0;
                cyc = 0;
                while (cnt < 8 && cyc < 40) begin
                    @(negedge clock);
                    cyc++;
                    if (cyc == 1)
                        chk("first_grant_after_rst", 32'(req_ready), 32'h1);
                    if (|req_ready) cnt++;
                end
                if (cnt < 8) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL fair_timeout: got %0d grants expected 8", cnt);
                end
                @(posedge clock);
                #1 req_valid = '0;
            end
            begin
                int cyc;
                cyc = 0;
                while (rsp_valid !== 1'b1 && cyc < 20) begin
                    @(negedge clock);
                    cyc++;
                end
                for (int i = 0; i < 8; i++) begin
                    chk("thru_valid", 32'(rsp_valid), 1);
                    @(negedge clock);
                end
                chk("thru_end", 32'(rsp_valid), 0);
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul16s_share_arb.md
# mul16s_share_arb

Round-robin scheduler that time-shares one truncated-operand 16×16 signed multiplier among `NREQ` requesters (systolic-array PE groups).
- Each requester presents operands and a tag over a valid/ready handshake.
- The block grants one request per cycle, pushes it through a 2-stage elastic pipeline (operand register, product register) and returns the product with requester id and tag on one response port.
- It is the sequencing and arbitration layer around the approximate 16-bit multiply datapath.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..16)
- `TAG_W`, 4, opaque tag width returned with each product

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_ready`  out  NREQ  request accepted this cycle (one-hot or zero)
- `req_a`  in  NREQ*16  signed operand A, requester i at [16i+15:16i]
- `req_b`  in  NREQ*16  signed operand B, same packing
- `req_tag`  in  NREQ*TAG_W  tag, same packing
- `rsp_valid`  out  1  product valid
- `rsp_ready`  in  1  consumer accepts product
- `rsp_id`  out  $clog2(NREQ)  index of the originating requester
- `rsp_tag`  out  TAG_W  tag echoed from the request
- `rsp_prod`  out  32  signed product
- `busy`  out  1  either pipeline stage holds a valid entry

## Operation
- Clock and reset: one clock `clock`; `reset_n` is asynchronous and active-low.
- Stage S1 (operand register) and stage S2 (product register) each hold a valid bit, id, tag and data.
- Arbitration:
  - Round-robin pointer `ptr`. The grant goes to the first `i` with `req_valid[i]`, searching upward from `ptr` with wrap-around.
  - `req_ready[i]` = `grant[i]` & `s1_accept`, where `s1_accept` = !S1.valid | S2 advance.
  - On a handshake, `ptr` becomes granted index + 1 (mod NREQ). Without a handshake, `ptr` holds.
- S1 → S2: S2 advances when !S2.valid or (`rsp_valid` & `rsp_ready`). The S1 contents move into S2 and the product is computed on that transfer.
- Arithmetic (approximate mode):
  - `za` = A[15:2], `zb` = B[15:2], both signed 14-bit.
  - `z` = `za`·`zb`, signed 28-bit.
  - `rsp_prod` = {`z`, 4'b0100}. This is the constant-biased truncated product. No saturation; the top result bit is the sign.
- Response: `rsp_valid` = S2.valid. While `rsp_valid` & !`rsp_ready`, `rsp_prod`, `rsp_id` and `rsp_tag` hold stable.
- Requester rules:
  - `req_valid[i]` must not depend on `req_ready[i]`.
  - Requesters may drop or change a request before its handshake; the arbiter re-evaluates every cycle.
- `NREQ`=1 degenerates to a plain 2-stage pipe. In that case `ptr` is constant 0.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_prod`=0, `rsp_id`=0, `rsp_tag`=0, `busy`=0, `ptr`=0.
- Reset asserted mid-operation discards all in-flight entries. No response is produced for them.
- Latency: a request handshaken at edge k gives `rsp_valid`=1 after edge k+1.
- Throughput: 1 product/cycle with `rsp_ready` held high.
- Full pipe: with S1 and S2 valid and `rsp_ready`=0, all `req_ready`=0.
- Simultaneous drain and fill: the S2 pop, the S1→S2 move and a new S1 push all occur on the same edge with no bubble.
- Response order equals grant order.

## Configuration
- `MUL16S_ARB_EXACT_EN` defined: `rsp_prod` = exact A·B (signed 32-bit) with no bias. Pipeline, latency and handshakes are unchanged.
- Undefined (default): approximate truncated-operand product as specified in Operation.

## Structure
- Package `mul16s_arb_pkg` holds:
  - `DATA_W`=16, `PROD_W`=32, `TRUNC_BITS`=2, `BIAS`=4'b0100
  - the request struct typedef {a, b, tag, id}
  - function `approx_mul(a, b)`
- One sub-module `rr_arbiter` (parameter `N`): inputs `req`, `ptr`; outputs one-hot `grant` and `grant_idx`. It is purely combinational.
- Pointer and pipeline registers live in the top module.

## Test plan
- Basic product: requester 0 sends A=0x0004, B=0x0004 → `rsp_prod`=0x00000014 (20), `rsp_id`=0, 2 edges later.
- Sign and extremes:
  - A=0xFFFC, B=0x0004 → 0xFFFFFFF4 (−12).
  - A=0x7FFF, B=0x7FFF → 0x3FFC_0014 (1073479700).
  - A=0, B=0x1234 → 0x00000004.
- Fairness: all 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,… with one product per cycle.
- Backpressure: fill the pipe, hold `rsp_ready`=0 for 5 cycles → `req_ready`=0 and the output stays stable. Release → two queued products drain in order and no request is lost or duplicated.
- Reset mid-flight: assert `reset_n`=0 with S1 and S2 valid → `rsp_valid`, `busy` and `req_ready` go to 0 immediately. After release, the first grant goes to requester 0.
- With `MUL16S_ARB_EXACT_EN` defined: A=0x7FFF, B=0x7FFF → 0x3FFF0001. Latency and handshakes are unchanged.
